serial_sum_deserializer: RTL

Receive side of the 8-bit serial adder datapath. Collects the LSB-first sum bits produced one per cycle by the Mealy serial adder, plus its final carry, into a parallel word. Presents that word to downstream logic through a valid/ready handshake. Tracks bit position with an internal up-counter, mirroring the down-counter that sequences the adder side.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/bit_up_counter.sv | 38 +++
 rtl/serial_sum_deserializer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the 8-bit serial adder datapath: default widths and
// the FSM encodings used by the receive-side deserializer.
package serial_adder_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 4;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_COLLECT = 2'b01;
    localparam logic [1:0] ST_HOLD    = 2'b10;

endpackage : serial_adder_pkg

// File: rtl/bit_up_counter.sv
// Bit-position up-counter for the deserializer; clear wins over enable.
module bit_up_counter #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // next-count selection
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_WIDTH{1'b0}};
        end else if (en) begin
            count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge i_clk) begin
        if (reset) begin
            count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : bit_up_counter

// File: rtl/serial_sum_deserializer.sv
// Receive side of the serial adder: gathers LSB-first sum bits and the final
// carry into a parallel word and offers it downstream via valid/ready.
module serial_sum_deserializer
    import serial_adder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  bit_valid,
    input  logic                  sum_bit,
    input  logic                  carry_in,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum_out,
    output logic                  carry_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  carry_q, carry_d;
    logic                  ovr_q, ovr_d;
    logic                  valid_q;
    logic                  busy_q;
    logic                  cnt_clr_s;
    logic                  cnt_en_s;
    logic [CNT_WIDTH-1:0]  cnt_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    bit_up_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .i_clk (i_clk),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .count (cnt_s)
    );

    assign shifted_s = {sum_bit, shift_q[DATA_WIDTH-1:1]};

    // FSM next-state, shift register and output capture
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        ovr_d     = ovr_q;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d   = {DATA_WIDTH{1'b0}};
                    cnt_clr_s = 1'b1;
                    state_d   = ST_COLLECT;
                end else if (bit_valid) begin
                    ovr_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                // start aborts the partial word and drops this cycle's bit
                if (start) begin
                    shift_d   = {DATA_WIDTH{1'b0}};
                    cnt_clr_s = 1'b1;
                end else if (bit_valid) begin
                    shift_d = shifted_s;
                    if (cnt_s == LAST_IDX) begin
                        sum_d     = shifted_s;
                        carry_d   = carry_in;
                        cnt_clr_s = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (bit_valid) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                if (out_ready) begin
                    if (start) begin
                        shift_d   = {DATA_WIDTH{1'b0}};
                        cnt_clr_s = 1'b1;
                        state_d   = ST_COLLECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // state, datapath and registered status outputs
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= {DATA_WIDTH{1'b0}};
            sum_q   <= {DATA_WIDTH{1'b0}};
            carry_q <= 1'b0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovr_q   <= ovr_d;
            valid_q <= (state_d == ST_HOLD);
            busy_q  <= (state_d == ST_COLLECT);
        end
    end

    assign sum_out   = sum_q;
    assign carry_out = carry_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule : serial_sum_deserializer
